// File: rtl/morse_pkg.sv
// Shared definitions for the Morse receive path.
//   state_e  : letter assembler FSM states
//   *_DEF    : default element limits and mark lengths
//   letter_t : letter code as emitted by the assembler (len, bits)
package morse_pkg;

    localparam int unsigned MAX_ELEM_DEF = 5;
    localparam int unsigned DOT_LEN_DEF  = 1;
    localparam int unsigned DASH_LEN_DEF = 3;

    // sym_len is three bits wide, so MAX_ELEM may not exceed 7.
    localparam int unsigned LEN_W = 3;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StGap,
        StErr
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]        len;
        logic [MAX_ELEM_DEF-1:0] bits;
    } letter_t;

endpackage

// File: rtl/morse_sym_reg.sv
// Single-entry valid/ready holding register with overrun detection.
// A load is accepted when the register is empty or is being drained in the
// same cycle; otherwise the incoming word is dropped and overrun is set.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : one-cycle request to store load_data
//   load_data  : word to store
//   out_ready  : downstream accepts sym_data when sym_valid is high
//   sym_valid  : register holds a word
//   sym_data   : held word
//   overrun    : sticky, set when a load was dropped; cleared only by rst
module morse_sym_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    input  logic             out_ready,
    output logic             sym_valid,
    output logic [Width-1:0] sym_data,
    output logic             overrun
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;
    logic             accept;
    logic             drop;

    always_comb begin
        accept    = load && (!valid_q || out_ready);
        drop      = load && valid_q && !out_ready;
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q | drop;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign sym_valid = valid_q;
    assign sym_data  = data_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/morse_letter_assembler.sv
// Morse letter assembler. Classifies each run of 1s on the serial line as a
// dot or a dash, collects up to MAX_ELEM elements, and on the space
// detector's completion pulse hands the letter to a valid/ready output
// register. Malformed marks and element overflow discard the letter.
// Optional feature macro: MORSE_ERR_CNT_EN adds err_cnt.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in        : serial bit, 1 = mark, 0 = gap
//   space_is  : one-cycle letter-complete pulse
//   out_ready : downstream ready
//   sym_valid : letter held
//   sym_len   : element count of held letter
//   sym_bits  : element i in bit i, 1 = dash
//   err       : one-cycle pulse when a letter is discarded
//   overrun   : sticky, a letter was dropped on a full output register
//   err_cnt   : (MORSE_ERR_CNT_EN only) saturating count of err pulses and drops
module morse_letter_assembler
    import morse_pkg::*;
#(
    parameter int unsigned MAX_ELEM = MAX_ELEM_DEF,
    parameter int unsigned DOT_LEN  = DOT_LEN_DEF,
    parameter int unsigned DASH_LEN = DASH_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    input  logic                space_is,
    input  logic                out_ready,
    output logic                sym_valid,
    output logic [LEN_W-1:0]    sym_len,
    output logic [MAX_ELEM-1:0] sym_bits,
    output logic                err,
    output logic                overrun
`ifdef MORSE_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    // Run counter saturates one above a dash so over-long marks stay invalid.
    localparam int unsigned        RunW    = $clog2(DASH_LEN + 2);
    localparam logic [RunW-1:0]    RunOne  = RunW'(1);
    localparam logic [RunW-1:0]    RunDot  = RunW'(DOT_LEN);
    localparam logic [RunW-1:0]    RunDash = RunW'(DASH_LEN);
    localparam logic [RunW-1:0]    RunSat  = RunW'(DASH_LEN + 1);
    localparam logic [LEN_W-1:0]   CntMax  = LEN_W'(MAX_ELEM);
    localparam int unsigned        WordW   = LEN_W + MAX_ELEM;

    state_e              state_q, state_d;
    logic [RunW-1:0]     run_q, run_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [MAX_ELEM-1:0] bits_q, bits_d;
    logic                err_q, err_d;

    logic                elem_ok;
    logic                elem_dash;
    logic [LEN_W-1:0]    app_cnt;
    logic [MAX_ELEM-1:0] app_bits;

    logic                load;
    logic [WordW-1:0]    load_word;
    logic [WordW-1:0]    sym_word;

    // Classification of the run currently held, valid when a mark ends.
    always_comb begin
        elem_dash = (run_q == RunDash);
        elem_ok   = ((run_q == RunDot) || elem_dash) && (cnt_q < CntMax);
        app_cnt   = cnt_q + LEN_W'(1);
        app_bits  = bits_q | (MAX_ELEM'(elem_dash) << cnt_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            run_q   <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
        end
    end

    // Next-state and element store.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        unique case (state_q)
            StIdle, StGap: begin
                if (in) begin
                    state_d = StMark;
                    run_d   = RunOne;
                end
            end
            StMark: begin
                if (in) begin
                    if (run_q < RunSat) begin
                        run_d = run_q + RunOne;
                    end
                end else begin
                    run_d = '0;
                    if (elem_ok) begin
                        state_d = StGap;
                        cnt_d   = app_cnt;
                        bits_d  = app_bits;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Letter completion overrides the above; a mark still high restarts.
        if (space_is && (state_q != StIdle)) begin
            cnt_d  = '0;
            bits_d = '0;
            if ((state_q == StMark) && in) begin
                state_d = StMark;
                run_d   = RunOne;
            end else begin
                state_d = StIdle;
                run_d   = '0;
            end
        end
    end

    // Outputs of the FSM: discard pulse and output-register load request.
    always_comb begin
        err_d     = 1'b0;
        load      = 1'b0;
        load_word = {cnt_q, bits_q};
        if (space_is) begin
            unique case (state_q)
                StIdle: begin
                    load = 1'b0;
                end
                StMark: begin
                    // A mark ending on this edge is appended first.
                    if (in || !elem_ok) begin
                        err_d = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_word = {app_cnt, app_bits};
                    end
                end
                StGap: begin
                    load = 1'b1;
                end
                StErr: begin
                    err_d = 1'b1;
                end
                default: begin
                    err_d = 1'b0;
                end
            endcase
        end
    end

    morse_sym_reg #(
        .Width(WordW)
    ) u_sym_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_word),
        .out_ready(out_ready),
        .sym_valid(sym_valid),
        .sym_data (sym_word),
        .overrun  (overrun)
    );

    assign sym_len  = sym_word[WordW-1:MAX_ELEM];
    assign sym_bits = sym_word[MAX_ELEM-1:0];
    assign err      = err_q;

`ifdef MORSE_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    logic       drop;

    assign drop = load && sym_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if ((err_d || drop) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_morse_letter_assembler.sv
module tb_morse_letter_assembler;
    import morse_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in;
    logic                    space_is;
    logic                    out_ready;
    logic                    sym_valid;
    logic [LEN_W-1:0]        sym_len;
    logic [MAX_ELEM_DEF-1:0] sym_bits;
    logic                    err;
    logic                    overrun;
`ifdef MORSE_ERR_CNT_EN
    logic [7:0]              err_cnt;
`endif

    morse_letter_assembler dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .space_is (space_is),
        .out_ready(out_ready),
        .sym_valid(sym_valid),
        .sym_len  (sym_len),
        .sym_bits (sym_bits),
        .err      (err),
        .overrun  (overrun)
`ifdef MORSE_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the output register as a one-slot mailbox, letters as mark lists.
    logic    m_valid;
    letter_t m_letter;
    logic    m_overrun;
    logic    m_err;
    int      m_err_cnt;

    logic    cur_good;
    letter_t cur_letter;
    int      marks[$];
    int      ready_mode;  // 0 low, 1 high, 2 random, 3 high only with space_is
    bit      rand_gaps;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic b, input logic sp);
        logic rdy;
        logic tr, ld, dr;
        case (ready_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = sp;
        endcase
        in        = b;
        space_is  = sp;
        out_ready = rdy;
        @(posedge clk);
        if (rst) begin
            m_valid   = 1'b0;
            m_letter  = '0;
            m_overrun = 1'b0;
            m_err     = 1'b0;
            m_err_cnt = 0;
        end else begin
            tr    = m_valid && rdy;
            ld    = sp && cur_good && (!m_valid || rdy);
            dr    = sp && cur_good && m_valid && !rdy;
            m_err = sp && !cur_good;
            if (ld) m_letter = cur_letter;
            m_valid = ld ? 1'b1 : (tr ? 1'b0 : m_valid);
            if (dr) m_overrun = 1'b1;
            if ((m_err || dr) && m_err_cnt < 255) m_err_cnt++;
        end
        #1;
        check("sym_valid", 32'(sym_valid), 32'(m_valid));
        check("err", 32'(err), 32'(m_err));
        check("overrun", 32'(overrun), 32'(m_overrun));
        if (m_valid) begin
            check("sym_len", 32'(sym_len), 32'(m_letter.len));
            check("sym_bits", 32'(sym_bits), 32'(m_letter.bits));
        end
`ifdef MORSE_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(m_err_cnt));
`endif
    endtask

    // Sends the marks queued in 'marks', then pulses space_is in a gap.
    task automatic send_letter();
        int n;
        int g;
        n          = marks.size();
        cur_good   = (n >= 1) && (n <= int'(MAX_ELEM_DEF));
        cur_letter = '0;
        foreach (marks[i]) begin
            if (marks[i] != int'(DOT_LEN_DEF) && marks[i] != int'(DASH_LEN_DEF)) cur_good = 1'b0;
        end
        if (cur_good) begin
            cur_letter.len = LEN_W'(n);
            foreach (marks[i]) cur_letter.bits[i] = (marks[i] == int'(DASH_LEN_DEF));
        end
        foreach (marks[i]) begin
            repeat (marks[i]) step(1'b1, 1'b0);
            if (i == n - 1) g = rand_gaps ? int'($urandom_range(1, 4)) : 3;
            else            g = rand_gaps ? int'($urandom_range(1, 3)) : 1;
            repeat (g) step(1'b0, 1'b0);
        end
        step(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        rst        = 1'b1;
        in         = 1'b0;
        space_is   = 1'b0;
        out_ready  = 1'b0;
        ready_mode = 1;
        rand_gaps  = 1'b0;
        cur_good   = 1'b0;
        cur_letter = '0;
        m_valid    = 1'b0;
        m_letter   = '0;
        m_overrun  = 1'b0;
        m_err      = 1'b0;
        m_err_cnt  = 0;
        do_reset();
        check("rst_valid", 32'(sym_valid), 0);
        check("rst_len", 32'(sym_len), 0);
        check("rst_bits", 32'(sym_bits), 0);
        check("rst_err", 32'(err), 0);
        check("rst_overrun", 32'(overrun), 0);

        // A: dot, dash
        marks = '{1, 3};
        send_letter();
        check("A_valid", 32'(sym_valid), 1);
        check("A_len", 32'(sym_len), 2);
        check("A_bits", 32'(sym_bits), 32'h02);
        step(1'b0, 1'b0);

        // Bad mark of two clocks
        marks = '{2};
        send_letter();
        check("bad_err", 32'(err), 1);
        check("bad_valid", 32'(sym_valid), 0);
        step(1'b0, 1'b0);
        check("bad_err_once", 32'(err), 0);

        // Overflow: six dots
        marks = '{1, 1, 1, 1, 1, 1};
        send_letter();
        check("ovf_err", 32'(err), 1);
        check("ovf_valid", 32'(sym_valid), 0);
        step(1'b0, 1'b0);

        // Same-cycle transfer and load: N held, W arrives with ready on its space_is
        do_reset();
        ready_mode = 0;
        marks = '{3, 1};
        send_letter();
        ready_mode = 3;
        marks = '{1, 3, 3};
        send_letter();
        check("same_valid", 32'(sym_valid), 1);
        check("same_len", 32'(sym_len), 3);
        check("same_bits", 32'(sym_bits), 32'h06);
        check("same_overrun", 32'(overrun), 0);
        ready_mode = 1;
        step(1'b0, 1'b0);
        check("same_drain", 32'(sym_valid), 0);

        // Backpressure: E then T with out_ready low
        ready_mode = 0;
        marks = '{1};
        send_letter();
        marks = '{3};
        send_letter();
        check("bp_valid", 32'(sym_valid), 1);
        check("bp_len", 32'(sym_len), 1);
        check("bp_bits", 32'(sym_bits), 0);
        check("bp_overrun", 32'(overrun), 1);
        ready_mode = 1;
        step(1'b0, 1'b0);
        check("bp_drain", 32'(sym_valid), 0);
        check("bp_sticky", 32'(overrun), 1);

        // Reset during the second clock of a dash, with a letter held
        ready_mode = 0;
        marks = '{1, 1};
        send_letter();
        step(1'b1, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        check("rm_valid", 32'(sym_valid), 0);
        check("rm_len", 32'(sym_len), 0);
        check("rm_bits", 32'(sym_bits), 0);
        check("rm_err", 32'(err), 0);
        check("rm_overrun", 32'(overrun), 0);
        repeat (3) step(1'b0, 1'b0);
        ready_mode = 1;
        marks = '{3, 1, 3};
        send_letter();
        check("rm_next_len", 32'(sym_len), 3);
        check("rm_next_bits", 32'(sym_bits), 32'h05);
        step(1'b0, 1'b0);

        // Randomized letters with random backpressure and gaps
        do_reset();
        rand_gaps  = 1'b1;
        ready_mode = 2;
        for (int k = 0; k < 60; k++) begin
            marks.delete();
            repeat ($urandom_range(1, 6)) begin
                r = int'($urandom_range(0, 19));
                if (r < 9)       marks.push_back(1);
                else if (r < 18) marks.push_back(3);
                else if (r < 19) marks.push_back(2);
                else             marks.push_back(int'($urandom_range(4, 6)));
            end
            send_letter();
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_letter_assembler.md
# morse_letter_assembler

Downstream consumer of the space detector in the Morse receive path. It samples the same serial bit stream, classifies each run of 1s as a dot or a dash, and accumulates up to five elements. When the space detector's completion pulse arrives, it emits one letter code through a valid/ready output register. Malformed marks and element overflow are flagged, and the affected letter is discarded.

## Interface
Parameters:
- MAX_ELEM, 5: maximum elements per letter; sets the width of sym_bits.
- DOT_LEN, 1: mark length, in clocks, that classifies as a dot.
- DASH_LEN, 3: mark length, in clocks, that classifies as a dash.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in  in  1  serial bit, one per clock; 1 = mark, 0 = gap.
- space_is  in  1  one-cycle pulse from the space detector; the letter is complete.
- out_ready  in  1  downstream accepts sym when high with sym_valid.
- sym_valid  out  1  letter code held and valid.
- sym_len  out  3  number of elements, 1..MAX_ELEM.
- sym_bits  out  MAX_ELEM  element i is in bit i, first element in bit 0; 1 = dash, 0 = dot; unused bits are 0.
- err  out  1  one-cycle pulse when a letter is discarded.
- overrun  out  1  sticky flag; a letter was dropped because the output register was full. Cleared only by rst.

## Operation
FSM states:
- IDLE: no elements, line in gap.
- MARK: counting 1s.
- GAP: at least one element held.
- ERR: discard until space.

Transitions and datapath:
- IDLE, in=1: go to MARK, run counter = 1.
- MARK, in=1: run counter increments, saturating at DASH_LEN+1.
- MARK, in=0: classify the run.
  - run == DOT_LEN: append a 0.
  - run == DASH_LEN: append a 1.
  - any other length: go to ERR.
  - If an append would exceed MAX_ELEM elements: go to ERR.
  - Otherwise go to GAP.
- GAP, in=1: go to MARK, run counter = 1.
- space_is, in GAP: attempt to load the output register, then clear the element store and go to IDLE.
- space_is, in ERR: pulse err, clear the store, go to IDLE.
- space_is, in IDLE: ignored.
- space_is, in MARK: the mark is incomplete. Treat as error: pulse err, clear the store, enter MARK with run = 1 if in=1, else IDLE.

Output register:
- Load when (!sym_valid || out_ready) at space_is.
- If sym_valid && !out_ready at space_is: drop the new letter, set overrun, leave the held letter unchanged.
- A transfer occurs when sym_valid && out_ready. With no simultaneous load, sym_valid clears the next cycle.
- Transfer and load in the same cycle: the new letter replaces the old one and sym_valid stays 1.

## Timing
- Reset values: sym_valid=0, sym_len=0, sym_bits=0, err=0, overrun=0, state IDLE, run counter 0, element count 0.
- Element classification is registered on the posedge where in=0 follows a 1.
- Letter latency: sym_valid rises at the posedge after the posedge sampling space_is (1 clock).
- err is asserted for exactly the cycle after the sampling posedge.
- If classification and space_is coincide, the element is appended first; the letter includes it.
- rst mid-letter or mid-handshake: everything returns to reset values next edge; the held letter is lost.
- out_ready may be high without sym_valid; this has no effect.

## Configuration
MORSE_ERR_CNT_EN:
- Defined: adds output err_cnt[7:0], which counts err pulses plus overrun drops. It saturates at 255 and resets to 0 on rst.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared morse_pkg:
  - FSM state enum (IDLE, MARK, GAP, ERR).
  - MAX_ELEM, DOT_LEN and DASH_LEN defaults.
  - Letter-code typedef struct {len, bits}.
- One sub-module, morse_sym_reg: a single-entry valid/ready holding register with overrun detection.
- Classifier and FSM live in the top module.

## Test plan
- A: drive in=1,0,1,1,1,0,0,0 with space_is after the third 0 and out_ready=1. Required: sym_valid 1 cycle later, sym_len=2, sym_bits=5'b00010.
- Bad mark: drive in=1,1,0,0,0 then space_is. Required: err pulses once, sym_valid stays 0.
- Overflow: drive six dots then space_is. Required: err pulses, no letter is emitted.
- Backpressure: hold out_ready=0, send E (single dot) then T (single dash).
  - Required: E held (sym_len=1, bits=0) and overrun=1.
  - Then raise out_ready: E transfers and sym_valid drops.
- Same-cycle transfer and load: a letter is held and out_ready=1 on the space_is cycle of the next letter. Required: the new letter is loaded, sym_valid stays 1, overrun stays 0.
- Reset mid-mark: rst during the 2nd 1 of a dash. Required: all outputs 0 next cycle; the following letter decodes normally.
